// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences ICache fetches and LSU loads/stores as little-endian
// byte accesses on an 8-bit RAM/I/O bus, returning a one-cycle completion
// pulse to whichever requester was served.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        iFlagIn,
    input  logic [31:0] iAddrIn,
    output logic        iValidOut,
    output logic [31:0] iDataOut,
    input  logic        dFlagIn,
    input  logic        dWriteIn,
    input  logic [1:0]  dSizeIn,
    input  logic [31:0] dAddrIn,
    input  logic [31:0] dDataIn,
    output logic        dValidOut,
    output logic [31:0] dDataOut,
    input  logic [7:0]  memDin,
    output logic [7:0]  memDout,
    output logic [31:0] memAddr,
    output logic        memWr,
    input  logic        ioBufferFull
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] base, base_nx;
    logic [31:0] wdata, wdata_nx;
    logic [2:0]  len, len_nx;
    logic [2:0]  icnt, icnt_nx;     // next byte to issue
    logic [2:0]  ccnt, ccnt_nx;     // next byte to capture
    logic        pend, pend_nx;     // a read byte was issued last cycle
    logic        restart, restart_nx;
    logic        req_d, req_d_nx;   // 1 = LSU owns the transfer
    logic [31:0] rbuf, rbuf_nx;
    logic [31:0] idata, idata_nx;
    logic [31:0] ddata, ddata_nx;

    logic [2:0]  issue_idx;
    logic        do_cap;
    logic        do_issue;
    logic [31:0] byte_addr;
    logic [31:0] rbuf_cap;

    assign iDataOut = idata;
    assign dDataOut = ddata;

    // State and datapath registers; nothing moves while readyIn is low
    // except the restart marker, which remembers that a stall happened.
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            state   <= IDLE;
            base    <= '0;
            wdata   <= '0;
            len     <= '0;
            icnt    <= '0;
            ccnt    <= '0;
            pend    <= 1'b0;
            restart <= 1'b0;
            req_d   <= 1'b0;
            rbuf    <= '0;
            idata   <= '0;
            ddata   <= '0;
        end else begin
            state   <= state_nx;
            base    <= base_nx;
            wdata   <= wdata_nx;
            len     <= len_nx;
            icnt    <= icnt_nx;
            ccnt    <= ccnt_nx;
            pend    <= pend_nx;
            restart <= restart_nx;
            req_d   <= req_d_nx;
            rbuf    <= rbuf_nx;
            idata   <= idata_nx;
            ddata   <= ddata_nx;
        end
    end

    // Arbitration, byte sequencing, bus outputs and completion pulses.
    always_comb begin
        state_nx   = state;
        base_nx    = base;
        wdata_nx   = wdata;
        len_nx     = len;
        icnt_nx    = icnt;
        ccnt_nx    = ccnt;
        pend_nx    = pend;
        req_d_nx   = req_d;
        rbuf_nx    = rbuf;
        idata_nx   = idata;
        ddata_nx   = ddata;
        restart_nx = ~readyIn;
        memWr      = 1'b0;
        memAddr    = '0;
        memDout    = '0;
        iValidOut  = 1'b0;
        dValidOut  = 1'b0;

        // After a stall the RAM pipeline is stale: drop the pending capture
        // and re-issue from the first byte not yet captured.
        issue_idx = restart ? ccnt : icnt;
        do_cap    = pend & ~restart;
        do_issue  = (issue_idx < len);
        byte_addr = '0;
        rbuf_cap  = rbuf;
        rbuf_cap[{ccnt[1:0], 3'b000} +: 8] = memDin;

        if (readyIn) begin
            case (state)
                IDLE: begin
                    if (dFlagIn) begin
                        base_nx  = dAddrIn;
                        wdata_nx = dDataIn;
                        case (dSizeIn)
                            2'b00:   len_nx = 3'd1;
                            2'b01:   len_nx = 3'd2;
                            default: len_nx = 3'd4;
                        endcase
                        req_d_nx = 1'b1;
                        state_nx = dWriteIn ? WRITE : READ;
                    end else if (iFlagIn) begin
                        base_nx  = iAddrIn;
                        len_nx   = 3'd4;
                        req_d_nx = 1'b0;
                        state_nx = READ;
                    end
                    icnt_nx = '0;
                    ccnt_nx = '0;
                    pend_nx = 1'b0;
                    rbuf_nx = '0;
                end
                READ: begin
                    if (do_issue) begin
                        byte_addr = base + {29'd0, issue_idx};
                        memAddr   = byte_addr;
                        icnt_nx   = issue_idx + 3'd1;
                    end
                    pend_nx = do_issue;
                    if (do_cap) begin
                        rbuf_nx = rbuf_cap;
                        ccnt_nx = ccnt + 3'd1;
                        if (ccnt == len - 3'd1) begin
                            if (req_d) ddata_nx = rbuf_cap;
                            else       idata_nx = rbuf_cap;
                            state_nx = DONE;
                        end
                    end
                end
                WRITE: begin
                    byte_addr = base + {29'd0, icnt};
                    if (!((byte_addr[17:16] == IO_HI) && ioBufferFull)) begin
                        memWr   = 1'b1;
                        memAddr = byte_addr;
                        memDout = wdata[{icnt[1:0], 3'b000} +: 8];
                        icnt_nx = icnt + 3'd1;
                        if (icnt == len - 3'd1) state_nx = DONE;
                    end
                end
                DONE: begin
                    iValidOut = ~req_d;
                    dValidOut = req_d;
                    state_nx  = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a
// byte-array memory model and transfer-level latency rules.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        iflag;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] idata;
    logic        dflag;
    logic        dwrite;
    logic [1:0]  dsize;
    logic [31:0] daddr;
    logic [31:0] ddin;
    logic        dvalid;
    logic [31:0] ddout;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic        io_full;

    int n_cmp = 0;
    int n_err = 0;

    mem_ctrl #(.IO_HI(2'b11)) dut (
        .clockIn(clk), .resetIn(rst_n), .readyIn(ready),
        .iFlagIn(iflag), .iAddrIn(iaddr), .iValidOut(ivalid), .iDataOut(idata),
        .dFlagIn(dflag), .dWriteIn(dwrite), .dSizeIn(dsize), .dAddrIn(daddr),
        .dDataIn(ddin), .dValidOut(dvalid), .dDataOut(ddout),
        .memDin(mem_din), .memDout(mem_dout), .memAddr(mem_addr), .memWr(mem_wr),
        .ioBufferFull(io_full)
    );

    always #5 clk = ~clk;

    // External RAM (environment) and expected memory contents (reference).
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    // RAM behaviour: write on strobe, read data returned one cycle later.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] = mem_dout;
        mem_din <= ram_rd(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_memwr"},   {31'd0, mem_wr},   32'd0);
        check({tag, "_memaddr"}, mem_addr,          32'd0);
        check({tag, "_memdout"}, {24'd0, mem_dout}, 32'd0);
        check({tag, "_ivalid"},  {31'd0, ivalid},   32'd0);
        check({tag, "_dvalid"},  {31'd0, dvalid},   32'd0);
        check({tag, "_idata"},   idata,             32'd0);
        check({tag, "_ddata"},   ddout,             32'd0);
    endtask

    // One request from start to completion. Expected latency follows the
    // transfer rules: reads N+2, writes N+1, plus stall cycles, plus one
    // re-issue cycle for a stalled read, plus I/O hold cycles.
    task automatic run_txn(input bit is_d, input bit wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int stall_at, input int stall_len, input int io_n);
        int n, exp_lat, got_lat, nw, hold;
        bit rd, all_io, other_seen, st;
        logic [31:0] exp_d, got_d;
        logic [31:0] wa [4];
        logic [7:0]  wdl [4];
        logic [31:0] wd_v;

        n  = !is_d ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        rd = !(is_d && wr);
        all_io = 1'b1;
        for (int j = 0; j < n; j++) begin
            logic [31:0] a;
            a = addr + 32'(j);
            if (a[17:16] != 2'b11) all_io = 1'b0;
        end
        hold    = (!rd && all_io) ? io_n : 0;
        exp_lat = (rd ? n + 2 : n + 1) + stall_len + ((rd && stall_len > 0) ? 1 : 0) + hold;
        exp_d   = '0;
        for (int j = 0; j < n; j++) exp_d |= 32'(ref_rd(addr + 32'(j))) << (8 * j);

        nw = 0; got_lat = -1; other_seen = 1'b0; got_d = '0; wd_v = wd;
        @(negedge clk);
        ready = 1'b1; io_full = 1'b0;
        if (is_d) begin
            dflag = 1'b1; dwrite = wr; dsize = size; daddr = addr; ddin = wd;
        end else begin
            iflag = 1'b1; iaddr = addr;
        end
        for (int k = 0; k < 60; k++) begin
            if (k > 0) begin
                @(negedge clk);
                st      = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
                ready   = !st;
                io_full = (k >= 1) && (k <= io_n);
            end else st = 1'b0;
            #1;
            if (st) check("stall_wr", {31'd0, mem_wr}, 32'd0);
            if (hold > 0 && k >= 1 && k <= hold) check("io_hold_wr", {31'd0, mem_wr}, 32'd0);
            if (rd && stall_len == 0 && k >= 1 && k <= n)
                check("raddr", mem_addr, addr + 32'(k - 1));
            if (!rd && stall_len == 0 && hold == 0 && k >= 1 && k <= n)
                check("wr_strobe", {31'd0, mem_wr}, 32'd1);
            if (mem_wr) begin
                if (nw < 4) begin wa[nw] = mem_addr; wdl[nw] = mem_dout; end
                nw++;
            end
            if (is_d ? ivalid : dvalid) other_seen = 1'b1;
            if (is_d ? dvalid : ivalid) begin
                got_lat = k;
                got_d   = is_d ? ddout : idata;
                iflag = 1'b0; dflag = 1'b0;
                break;
            end
        end
        if (got_lat < 0) begin
            check("timeout", 32'd0, 32'd1);
            iflag = 1'b0; dflag = 1'b0;
        end
        check("latency", 32'(got_lat), 32'(exp_lat));
        check("wrong_requester", {31'd0, other_seen}, 32'd0);
        if (rd) begin
            check("rd_nowr", 32'(nw), 32'd0);
            check("rd_data", got_d, exp_d);
        end else begin
            check("wr_cnt", 32'(nw), 32'(n));
            for (int j = 0; j < n && j < nw; j++) begin
                check("wr_addr", wa[j], addr + 32'(j));
                check("wr_data", {24'd0, wdl[j]}, {24'd0, wd_v[8*j +: 8]});
                ref_mem[addr + 32'(j)] = wd_v[8*j +: 8];
            end
        end
        ready = 1'b1; io_full = 1'b0;
        @(negedge clk); #1;
        check("pulse_once", {30'd0, ivalid, dvalid}, 32'd0);
        if (!rd)
            for (int j = 0; j < n; j++)
                check("ram_rb", {24'd0, ram_rd(addr + 32'(j))}, {24'd0, ref_rd(addr + 32'(j))});
    endtask

    initial begin
        int t_d, t_i;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          isd, w;
        int          sa, sl, io, region, nb;

        rst_n = 1'b0; ready = 1'b1; io_full = 1'b0;
        iflag = 1'b1; iaddr = 32'h1000; dflag = 1'b1; dwrite = 1'b0;
        dsize = 2'b10; daddr = 32'h2000; ddin = '0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        ref_mem[32'h1000] = 8'h13; ref_mem[32'h1001] = 8'h05; ref_mem[32'h1002] = 8'h00; ref_mem[32'h1003] = 8'h00;

        // Reset held two cycles with both flags high.
        @(negedge clk); #1; check_reset_outputs("rst1");
        @(negedge clk); #1; check_reset_outputs("rst2");
        iflag = 1'b0; dflag = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Word fetch, word store, I/O back-pressure, stalls.
        run_txn(1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0, 0, 0, 0);
        check("fetch_word", idata, 32'h0000_0513);
        run_txn(1'b1, 1'b1, 2'b10, 32'h0000_2000, 32'hDEAD_BEEF, 0, 0, 0);
        run_txn(1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'h0, 0, 0, 0);
        check("store_readback", ddout, 32'hDEAD_BEEF);
        run_txn(1'b1, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041, 0, 0, 3);
        run_txn(1'b1, 1'b1, 2'b01, 32'h0000_2010, 32'h0000_A55A, 0, 0, 2);
        run_txn(1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0, 3, 2, 0);
        run_txn(1'b1, 1'b1, 2'b10, 32'h0000_2004, 32'h1234_5678, 2, 2, 0);
        run_txn(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, 0, 0, 0);

        // Simultaneous fetch and byte load: LSU first, fetch right after.
        @(negedge clk);
        iflag = 1'b1; iaddr = 32'h1000;
        dflag = 1'b1; dwrite = 1'b0; dsize = 2'b00; daddr = 32'h2001;
        t_d = -1; t_i = -1;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (dvalid && t_d < 0) begin t_d = k; check("simul_ddata", ddout, 32'h0000_00BE); dflag = 1'b0; end
            if (ivalid) begin t_i = k; check("simul_idata", idata, 32'h0000_0513); iflag = 1'b0; break; end
        end
        iflag = 1'b0; dflag = 1'b0;
        check("simul_dlat", 32'(t_d), 32'd3);
        check("simul_ilat", 32'(t_i), 32'd10);

        // Reset in the middle of a fetch clears everything.
        @(negedge clk);
        iflag = 1'b1; iaddr = 32'h1000;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst_n = 1'b0; iflag = 1'b0;
        @(negedge clk); #1; check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic.
        for (int t = 0; t < 50; t++) begin
            isd    = ($urandom % 3) != 0;
            w      = isd && ($urandom % 2 == 1);
            sz     = 2'($urandom % 4);
            region = int'($urandom % 4);
            case (region)
                0: a = $urandom;
                1: a = 32'hFFFF_FFFC + 32'($urandom % 4);
                2: begin
                    a = $urandom;
                    a[17:16] = 2'b11;
                    a[15:0]  = 16'($urandom_range(0, 65519));
                end
                default: a = 32'h2000 + 32'($urandom % 16);
            endcase
            nb = !isd ? 4 : (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            sa = 0; sl = 0; io = 0;
            if (w && region >= 2 && ($urandom % 2 == 1)) begin
                io = int'($urandom_range(1, 3));
            end else if ($urandom % 2 == 1) begin
                sl = int'($urandom_range(1, 3));
                sa = w ? int'($urandom_range(1, nb)) : int'($urandom_range(2, nb + 1));
            end
            run_txn(isd, w, sz, a, $urandom, sa, sl, io);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that sits between the instruction cache, the load/store unit and the byte-wide external RAM/I/O bus. It serves ICache miss requests and LSU loads/stores of 1, 2 or 4 bytes. It sequences each request as little-endian byte accesses on the 8-bit RAM port and returns a one-cycle completion pulse to the requester. It is the responder side of the ICache's memFlag/addrOut/validIn/dataIn handshake.

## Interface
- `IO_HI`, default 2'b11: an address is I/O when addr[17:16] == IO_HI.
- `clockIn`  in  1  system clock.
- `resetIn`  in  1  synchronous, active-low reset.
- `readyIn`  in  1  global enable; low = stall.
- `iFlagIn`  in  1  ICache request (level, held until iValidOut).
- `iAddrIn`  in  32  ICache fetch address, stable while iFlagIn high.
- `iValidOut`  out  1  fetch complete, one-cycle pulse.
- `iDataOut`  out  32  fetched word.
- `dFlagIn`  in  1  LSU request (level, held until dValidOut).
- `dWriteIn`  in  1  1 = store, 0 = load.
- `dSizeIn`  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as word.
- `dAddrIn`  in  32  LSU address, stable while dFlagIn high.
- `dDataIn`  in  32  store data, low bytes used.
- `dValidOut`  out  1  LSU access complete, one-cycle pulse.
- `dDataOut`  out  32  load data, zero-extended; the LSU sign-extends.
- `memDin`  in  8  RAM read data for the address driven in the previous cycle.
- `memDout`  out  8  RAM write data.
- `memAddr`  out  32  RAM byte address.
- `memWr`  out  1  RAM write strobe.
- `ioBufferFull`  in  1  I/O output buffer full.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, arbitration: if dFlagIn is high, accept the LSU request; else if iFlagIn is high, accept the fetch. The LSU has fixed priority. Accepting latches the address, the length N (1/2/4; fetch is always 4), the store data and the requester id.
- READ: byte k is issued as memAddr = base + k for k = 0..N-1, one per cycle.
  - memDin is captured into lane k (bits 8k+7:8k) in the cycle after byte k is issued.
  - After the last capture, go to DONE. Unused lanes of dDataOut are 0.
- WRITE: byte k is driven with memAddr = base + k, memDout = data lane k and memWr = 1, one per cycle. After byte N-1, go to DONE.
- I/O stores: while ioBufferFull is high, the current byte is not issued (memWr = 0) and the counter holds.
- DONE: pulse the requester's valid for one cycle with the data register already updated, ignore both flags, then return to IDLE. The requester drops its flag on this edge, so it is never served twice.
- When no write byte is issued, memWr = 0, memAddr = 0 and memDout = 0.
- readyIn low: no register updates and memWr is forced to 0.
  - A write byte pending during the stall is issued on the first ready cycle, exactly once.
  - For reads, the byte whose data was outstanding at stall onset is re-issued; the RAM pipeline restarts from the first uncaptured byte.
- Reset (resetIn = 0 at an edge) aborts any transfer and returns to IDLE. All outputs go to 0, including iDataOut and dDataOut.
- iDataOut and dDataOut hold their last value until the next completion for that requester.

## Timing
- Request sampled in IDLE at cycle c0; first byte issued in c1.
- Read of N bytes: valid pulse in cycle c0+N+2 (fetch: c0+6).
- Write of N bytes: valid pulse in cycle c0+N+1 (word store: c0+5).
- Each stall cycle, and each cycle ioBufferFull holds a byte, adds one cycle. A stall during a read adds one more cycle for the re-issue.
- A new request is accepted no earlier than the cycle after DONE. Back-to-back word fetches therefore start every 7 cycles.
- Address arithmetic wraps mod 2^32. No alignment requirement: half/word accesses may cross any byte boundary.

## Test plan
- **Reset:** hold resetIn = 0 for 2 cycles with both flags high -> all outputs 0. After release the FSM is in IDLE and requests are served normally.
- **Word fetch:** fetch 0x00001000 with RAM bytes 13 05 00 00 -> memAddr 0x1000..0x1003 in c1..c4, memWr = 0 throughout, iValidOut a single pulse at c6, iDataOut = 0x00000513.
- **Word store:** store 0xDEADBEEF to 0x2000 -> memWr = 1 in c1..c4 with memDout EF, BE, AD, DE at 0x2000..0x2003, dValidOut at c5, RAM reads back 0xDEADBEEF.
- **Simultaneous requests:** iFlagIn and a byte load from 0x2001 raised in the same cycle -> the load is served first (dValidOut at c3, dDataOut = 0x000000BE). The fetch is accepted in the IDLE cycle after DONE.
- **I/O back-pressure:** byte store 0x41 to 0x00030000 with ioBufferFull high for 3 cycles -> memWr stays 0 for those 3 cycles, then goes high for exactly one cycle with memDout = 0x41, then dValidOut.
- **Stall during fetch:** readyIn low for 2 cycles in the middle of a word fetch, and separately in the middle of a word store -> the fetch returns the correct word with no lane corruption; the store writes each byte exactly once; memWr = 0 during the stall.
